// File: rtl/sum_serie_ctrl.sv
// Serial wide adder/subtractor: one 4-bit carry-lookahead slice reused per
// clock, LSB nibble first, with the carry chained through a register.

module sum4 (
  output logic [3:0] S,
  output logic       C_out,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is a flat function of generate/propagate and c_in.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign S     = p ^ c[3:0];
  assign C_out = c[4];
endmodule

module sum_serie_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   c_out,
  output logic                   ovf
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [IW+1:0]  base;
  logic [3:0]     nib_s;
  logic           nib_c;
  logic           last;

  assign base = {idx, 2'b00};
  assign last = (idx == IW'(NIBBLES - 1));

  sum4 u_sum4 (
    .S     (nib_s),
    .C_out (nib_c),
    .A     (a_q[base +: 4]),
    .B     (b_q[base +: 4]),
    .c_in  (carry)
  );

  // Control FSM; subtract is folded in as A + ~B with carry-in 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= op ? ~b : b;
            carry <= op;
            idx   <= '0;
            s     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s[base +: 4] <= nib_s;
          carry        <= nib_c;
          if (last) begin
            c_out <= nib_c;
            ovf   <= (a_q[W-1] == b_q[W-1]) && (nib_s[3] != a_q[W-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sum_serie_ctrl.md
Name: sum_serie_ctrl

Overview:
Multi-cycle controller that performs wide add/subtract by sequencing a single sum4 carry-lookahead adder one nibble per clock, LSB nibble first. It chains the carry between cycles through a carry register. It gives the rest of the datapath a 4*NIBBLES-bit adder/subtractor with a start/done handshake, at the cost of one sum4 instance.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (minimum 2).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = A+B, 1 = A-B (A + ~B + 1); sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result valid
s  output  W  result register; holds until next accepted start
c_out  output  1  carry out of MSB slice (subtract: 1 = no borrow)
ovf  output  1  two's-complement overflow of the full-width operation

Behaviour:
- Reset (async, any state): state=IDLE, index=0, carry reg=0, operand regs=0.
- Reset also clears outputs: s=0, c_out=0, ovf=0, busy=0, done=0.
- Datapath: one sum4 instance, ports in order (S, C_out, A, B, c_in).
  - Inputs: nibble[index] of latched A, nibble[index] of latched B', and the carry reg.
  - No other arithmetic on the sum path.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch A; latch B' = op ? ~b : b; carry reg = op; index=0; clear s; go RUN.
  - start=0: remain in IDLE.
- RUN (busy=1):
  - Each edge: write sum4 S into s[4*index+3:4*index]; carry reg = sum4 C_out.
  - index < NIBBLES-1: index+1, stay in RUN.
  - index = NIBBLES-1: c_out = sum4 C_out; ovf = (A[W-1] == B'[W-1]) && (S[3] != A[W-1]); go DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: start sampled at edge t0 → busy during cycles t0..t0+NIBBLES → done high during cycle after edge t0+NIBBLES. Throughput: one operation per NIBBLES+2 cycles.
- start in RUN or DONE: ignored, no queueing. a/b/op may change freely after the accepting edge; the latched copies are used.
- s, c_out, ovf: stable from DONE until the next accepted start.
- s is cleared at accept, so s shows partial results while busy. Consumers use s only when done=1 or in IDLE.
- Reset asserted mid-RUN: operation aborted, no done pulse; after release, block is in IDLE ready for start.
- Carry wrap: carry out of the MSB slice goes to c_out only; never fed back into the next operation.

Test Plan:
- NIBBLES=4, op=0, a=0x1234, b=0x4321, start 1 cycle → busy 4 cycles, done 1 cycle; s=0x5555, c_out=0, ovf=0.
- op=0, a=0xFFFF, b=0x0001 → s=0x0000, c_out=1, ovf=0. Confirms carry ripples across all 4 nibble cycles.
- op=0, a=0x7FFF, b=0x0001 → s=0x8000, c_out=0, ovf=1. Then op=1, a=0x8000, b=0x0001 → s=0x7FFF, c_out=1, ovf=1.
- op=1, a=0x0005, b=0x0007 → s=0xFFFE, c_out=0 (borrow), ovf=0. Then op=1, a=0x0007, b=0x0005 → s=0x0002, c_out=1.
- Accept a=0x1111,b=0x1111; hold start=1 and change a=0xFFFF through RUN and DONE. Required: only one done pulse, s=0x2222, second operation starts only from IDLE.
- Assert reset for 1 cycle at the 2nd RUN cycle. Required: busy/done/s/c_out/ovf go 0 immediately, state IDLE, no done pulse. Next start with a=0x0F0F, b=0x00F1 gives s=0x1000.
